// File: rtl/pk_coeff_sched_pkg.sv
// Shared parameters, state encoding and helpers for the public-key coefficient scheduler.
package pk_coeff_sched_pkg;

    localparam int KYBER_N       = 256;
    localparam int KYBER_K       = 3;
    localparam int KYBER_R_WIDTH = 12;
    localparam int KYBER_Q       = 3329;

    localparam int RHO_W  = 256;
    localparam int POLY_W = KYBER_R_WIDTH * KYBER_N;
    localparam int PK_W   = KYBER_N + KYBER_K * KYBER_R_WIDTH * KYBER_N;

    localparam int POLY_IDX_W = 2;
    localparam int COEF_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RHO    = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } pk_sched_state_t;

    // A decoded coefficient is only legal when it is already reduced below q.
    function automatic logic coef_out_of_range(input logic [KYBER_R_WIDTH-1:0] coef);
        return (coef >= KYBER_R_WIDTH'(KYBER_Q));
    endfunction

endpackage

// File: rtl/pk_coeff_sched_coef_mux.sv
// Combinational select of one 12-bit coefficient field from the latched t_hat bits.
module pk_coef_mux
    import pk_coeff_sched_pkg::*;
(
    input  logic [PK_W-RHO_W-1:0]    pk_coefs,
    input  logic [POLY_IDX_W-1:0]    sel_poly,
    input  logic [COEF_IDX_W-1:0]    sel_idx,
    output logic [KYBER_R_WIDTH-1:0] coef
);

    logic [13:0] base_s;

    // Bit offset of (poly, idx) inside the coefficient area; an unused poly code reads as zero.
    always_comb begin
        base_s = 14'(sel_poly) * 14'(POLY_W) + 14'(sel_idx) * 14'(KYBER_R_WIDTH);
        coef   = 12'd0;
        if (sel_poly < POLY_IDX_W'(KYBER_K)) begin
            coef = pk_coefs[base_s +: KYBER_R_WIDTH];
        end else begin
            coef = 12'd0;
        end
    end

endmodule

// File: rtl/pk_coeff_sched.sv
// Public-key sequencer: snapshots the key, hands rho to the sampler, then streams t_hat.
// Optional coefficient range flag is built only when PK_COEF_RANGE_CHECK_EN is defined.
module pk_coeff_sched
    import pk_coeff_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PK_W-1:0]          pk_in,
    output logic                     busy,
    output logic                     done,
    output logic [RHO_W-1:0]         rho_out,
    output logic                     rho_valid,
    input  logic                     rho_ready,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic [KYBER_R_WIDTH-1:0] coef_data,
    output logic [POLY_IDX_W-1:0]    coef_poly,
    output logic [COEF_IDX_W-1:0]    coef_idx,
    output logic                     coef_last,
    output logic                     coef_err
);

    pk_sched_state_t state_r;
    pk_sched_state_t state_nxt_s;

    logic [PK_W-1:0]          pk_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     rho_valid_r;
    logic                     coef_valid_r;
    logic [KYBER_R_WIDTH-1:0] coef_data_r;
    logic [POLY_IDX_W-1:0]    coef_poly_r;
    logic [COEF_IDX_W-1:0]    coef_idx_r;
    logic                     coef_last_r;

    logic                     accept_s;
    logic                     rho_hs_s;
    logic                     coef_hs_s;
    logic                     load_coef_s;
    logic [POLY_IDX_W-1:0]    sel_poly_s;
    logic [COEF_IDX_W-1:0]    sel_idx_s;
    logic                     sel_last_s;
    logic [KYBER_R_WIDTH-1:0] mux_coef_s;

    assign accept_s    = (state_r == IDLE) && start;
    assign rho_hs_s    = rho_valid_r && rho_ready;
    assign coef_hs_s   = coef_valid_r && coef_ready;
    assign load_coef_s = rho_hs_s || (coef_hs_s && !coef_last_r);

    // Next-state decode; ready inputs only steer state, never the registered valids directly.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RHO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RHO: begin
                if (rho_hs_s) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = RHO;
                end
            end
            STREAM: begin
                if (coef_hs_s && coef_last_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Index of the coefficient to present next: (0,0) when leaving RHO, otherwise the successor.
    always_comb begin
        sel_poly_s = coef_poly_r;
        sel_idx_s  = coef_idx_r;
        if (state_r == RHO) begin
            sel_poly_s = 2'd0;
            sel_idx_s  = 8'd0;
        end else if (coef_idx_r == COEF_IDX_W'(KYBER_N - 1)) begin
            sel_poly_s = coef_poly_r + 2'd1;
            sel_idx_s  = 8'd0;
        end else begin
            sel_poly_s = coef_poly_r;
            sel_idx_s  = coef_idx_r + 8'd1;
        end
        sel_last_s = (sel_poly_s == POLY_IDX_W'(KYBER_K - 1)) &&
                     (sel_idx_s == COEF_IDX_W'(KYBER_N - 1));
    end

    pk_coef_mux u_coef_mux (
        .pk_coefs (pk_r[PK_W-1:RHO_W]),
        .sel_poly (sel_poly_s),
        .sel_idx  (sel_idx_s),
        .coef     (mux_coef_s)
    );

    // State register and flag outputs, all decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rho_valid_r  <= 1'b0;
            coef_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s == RHO) || (state_nxt_s == STREAM);
            done_r       <= (state_nxt_s == DONE);
            rho_valid_r  <= (state_nxt_s == RHO);
            coef_valid_r <= (state_nxt_s == STREAM);
        end
    end

    // Key snapshot; rho_out is a view of it, so it persists until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_r <= '0;
        end else if (accept_s) begin
            pk_r <= pk_in;
        end else begin
            pk_r <= pk_r;
        end
    end

    // Coefficient output register: advances only on a handshake, so it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_data_r <= 12'd0;
            coef_poly_r <= 2'd0;
            coef_idx_r  <= 8'd0;
            coef_last_r <= 1'b0;
        end else if (accept_s) begin
            coef_data_r <= 12'd0;
            coef_poly_r <= 2'd0;
            coef_idx_r  <= 8'd0;
            coef_last_r <= 1'b0;
        end else if (load_coef_s) begin
            coef_data_r <= mux_coef_s;
            coef_poly_r <= sel_poly_s;
            coef_idx_r  <= sel_idx_s;
            coef_last_r <= sel_last_s;
        end else begin
            coef_data_r <= coef_data_r;
            coef_poly_r <= coef_poly_r;
            coef_idx_r  <= coef_idx_r;
            coef_last_r <= coef_last_r;
        end
    end

`ifdef PK_COEF_RANGE_CHECK_EN
    logic coef_err_r;

    // Sticky flag for any accepted coefficient at or above q; cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_err_r <= 1'b0;
        end else if (accept_s) begin
            coef_err_r <= 1'b0;
        end else if (coef_hs_s && coef_out_of_range(coef_data_r)) begin
            coef_err_r <= 1'b1;
        end else begin
            coef_err_r <= coef_err_r;
        end
    end

    assign coef_err = coef_err_r;
`else
    assign coef_err = 1'b0;
`endif

    assign busy       = busy_r;
    assign done       = done_r;
    assign rho_out    = pk_r[RHO_W-1:0];
    assign rho_valid  = rho_valid_r;
    assign coef_valid = coef_valid_r;
    assign coef_data  = coef_data_r;
    assign coef_poly  = coef_poly_r;
    assign coef_idx   = coef_idx_r;
    assign coef_last  = coef_last_r;

endmodule

// File: tb/tb_pk_coeff_sched.sv
// Scoreboard bench for pk_coeff_sched: stimulus pushes expected rho/coefficients, a monitor pops on handshakes.
module tb_pk_coeff_sched;
    import pk_coeff_sched_pkg::*;

    typedef struct packed {
        logic [11:0] data;
        logic [1:0]  poly;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [PK_W-1:0] pk_in = '0;
    logic            busy, done, rho_valid, coef_valid, coef_last, coef_err;
    logic            rho_ready = 1'b0;
    logic            coef_ready = 1'b0;
    logic [255:0]    rho_out;
    logic [11:0]     coef_data;
    logic [1:0]      coef_poly;
    logic [7:0]      coef_idx;

    exp_t         exp_q[$];
    logic [255:0] rho_q[$];
    exp_t         mon_got;
    int  n_checks = 0;
    int  n_pass = 0;
    int  done_cnt = 0;
    int  done_base = 0;
    bit  exp_err = 1'b0;
    bit  rand_ready = 1'b0;
    int  rho_delay = 0;
    int  rho_wait = 0;

    pk_coeff_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pk_in(pk_in),
        .busy(busy), .done(done), .rho_out(rho_out),
        .rho_valid(rho_valid), .rho_ready(rho_ready),
        .coef_valid(coef_valid), .coef_ready(coef_ready),
        .coef_data(coef_data), .coef_poly(coef_poly), .coef_idx(coef_idx),
        .coef_last(coef_last), .coef_err(coef_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [11:0] coef_val(input int pat, input int i, input int c);
        if (pat == 1) return 12'((c * 11 + i * 500 + 7) % 3329);
        if (pat == 2 && i == 2 && c == 7) return 12'hFFF;
        return 12'((i * 256 + c) % 3329);
    endfunction

    function automatic logic [255:0] rho_of(input int pat);
        if (pat == 1) return {32{8'h3C}};
        return {32{8'hA5}};
    endfunction

    task automatic load_pk(input int pat);
        pk_in[255:0] = rho_of(pat);
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 256; c++)
                pk_in[256 + i * 3072 + 12 * c +: 12] = coef_val(pat, i, c);
    endtask

    task automatic issue_start(input int pat);
        exp_t e;
        load_pk(pat);
        start = 1'b1;
        rho_q.push_back(rho_of(pat));
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 256; c++) begin
                e.data = coef_val(pat, i, c);
                e.poly = 2'(i);
                e.idx  = 8'(c);
                e.last = (i == 2 && c == 255);
                exp_q.push_back(e);
            end
        @(posedge clk); #1;
        start = 1'b0;
        exp_err = 1'b0;
        check("rho_latency", {busy, rho_valid}, 2'b11);
    endtask

    task automatic wait_done(input bit poke_start);
        bit found = 1'b0;
        for (int k = 0; k < 5000 && !found; k++) begin
            @(posedge clk); #1;
            if (done) found = 1'b1;
        end
        check("done_seen", found, 1'b1);
        if (found && poke_start) begin
            load_pk(1);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt - done_base, 1);
        check("coef_q_drained", exp_q.size(), 0);
        check("rho_q_drained", rho_q.size(), 0);
        check("idle_after", {busy, rho_valid, coef_valid, done}, 4'b0000);
        done_base = done_cnt;
    endtask

    // Ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            coef_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
            if (rho_valid) begin
                rho_ready = (rho_wait >= rho_delay);
                rho_wait++;
            end else begin
                rho_wait = 0;
                rho_ready = (rho_delay == 0);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("coef_err", coef_err, exp_err);
                if (rho_valid) begin
                    if (rho_q.size() == 0) check("rho_extra", rho_valid, 1'b0);
                    else begin
                        check("rho_out", rho_out, rho_q[0]);
                        if (rho_ready) void'(rho_q.pop_front());
                    end
                end
                if (coef_valid) begin
                    mon_got = {coef_data, coef_poly, coef_idx, coef_last};
                    if (exp_q.size() == 0) check("coef_extra", coef_valid, 1'b0);
                    else begin
                        check("coef", mon_got, exp_q[0]);
                        if (coef_ready) begin
`ifdef PK_COEF_RANGE_CHECK_EN
                            if (exp_q[0].data >= 12'd3329) exp_err = 1'b1;
`endif
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_busy", {busy, coef_valid, rho_valid}, 3'b000);
                end
            end
        end
    end

    initial begin
        bit hit;
        // Reset and idle
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {busy, done, rho_valid, coef_valid, coef_last, coef_err}, 6'd0);
        check("rst_rho", rho_out, 256'd0);
        check("rst_coef", {coef_data, coef_poly, coef_idx}, 22'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("idle", {busy, rho_valid, coef_valid, done}, 4'b0000);
        end

        // Basic stream, ready tied high
        issue_start(0);
        wait_done(1'b0);

        // Backpressure
        rand_ready = 1'b1;
        rho_delay = 5;
        issue_start(0);
        wait_done(1'b0);
        rand_ready = 1'b0;
        rho_delay = 0;

        // Snapshot and ignored starts (mid-stream and in the done cycle)
        issue_start(0);
        repeat (50) @(posedge clk);
        #1;
        load_pk(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("no_restart", {busy, coef_valid, rho_valid}, 3'b110);
        wait_done(1'b1);
        check("rho_hold", rho_out, {32{8'hA5}});

        // Reset mid-stream at (1,100)
        issue_start(0);
        hit = 1'b0;
        for (int k = 0; k < 3000 && !hit; k++) begin
            @(posedge clk); #1;
            if (coef_valid && coef_poly == 2'd1 && coef_idx == 8'd100) hit = 1'b1;
        end
        check("reached_1_100", hit, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        rho_q.delete();
        exp_err = 1'b0;
        #1;
        check("midrst_flags", {busy, done, rho_valid, coef_valid, coef_last}, 5'd0);
        check("midrst_coef", {coef_data, coef_poly, coef_idx}, 22'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - done_base, 0);
        issue_start(1);
        wait_done(1'b0);

        // Range check pattern: (2,7) = 4095
        issue_start(2);
        wait_done(1'b0);
`ifdef PK_COEF_RANGE_CHECK_EN
        check("err_after_done", coef_err, 1'b1);
`else
        check("err_tied_low", coef_err, 1'b0);
`endif
        issue_start(0);
        check("err_cleared", coef_err, 1'b0);
        wait_done(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
